// File: rtl/rv_dbg_pkg.sv
// rtl/rv_dbg_pkg.sv - shared types and constants for the memory dump reader
// Contents: dump FSM state enum, doubleword byte stride, skid FIFO depth and
// the width of the FIFO occupancy count.
package rv_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_e;

    localparam int unsigned DW_STRIDE  = 8;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/dump_skid_fifo.sv
// rtl/dump_skid_fifo.sv - 2-entry skid FIFO holding {address tag, data} words
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          write push_data_i at the tail
//   push_data_i     entry to store
//   pop_i           drop the head entry (caller guarantees non-empty)
//   head_o          current head entry
//   count_o         current occupancy (0..FIFO_DEPTH)
// Simultaneous push and pop is legal at any occupancy, including full.
module dump_skid_fifo
    import rv_dbg_pkg::*;
#(
    parameter int W = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [W-1:0]          push_data_i,
    input  logic                  pop_i,
    output logic [W-1:0]          head_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
                2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - streams a run of doublewords from memory with address tags
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, base_addr_i,
//   word_cnt_i                 dump request (base forced doubleword-aligned)
//   busy_o, done_o             dump in progress / one-cycle completion pulse
//   mem_re_o, mem_addr_o,
//   mem_rdata_i                memory read port, data returns one cycle later
//   dout_valid_o, dout_ready_i,
//   dout_data_o, dout_addr_o   output stream of {data, byte address tag}
module mem_dump_reader
    import rv_dbg_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [XLEN-1:0]  base_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mem_re_o,
    output logic [XLEN-1:0]  mem_addr_o,
    input  logic [XLEN-1:0]  mem_rdata_i,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic [XLEN-1:0]  dout_data_o,
    output logic [XLEN-1:0]  dout_addr_o
);

    localparam int ENT_W = 2 * XLEN;

    dump_state_e           state_q, state_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]      remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic [XLEN-1:0]       inflight_addr_q, inflight_addr_d;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [ENT_W-1:0]      fifo_head;
    logic                  fifo_empty;
    logic                  handshake;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  issue;
    logic                  done;
    logic                  accept;
    logic [FIFO_CNT_W:0]   pending;

    assign fifo_empty = (fifo_count == '0);

    // Returning read data bypasses the FIFO when it is empty, so a word is
    // offered on the same cycle its data arrives.
    assign dout_valid_o = !fifo_empty || inflight_q;
    assign handshake    = dout_valid_o && dout_ready_i;
    assign fifo_pop     = handshake && !fifo_empty;
    assign fifo_push    = inflight_q && !(fifo_empty && dout_ready_i);

    assign dout_data_o = !fifo_empty ? fifo_head[XLEN-1:0]
                       : (inflight_q ? mem_rdata_i : '0);
    assign dout_addr_o = !fifo_empty ? fifo_head[ENT_W-1:XLEN]
                       : (inflight_q ? inflight_addr_q : '0);

    // Words owed to the sink after this cycle; a new read may only be
    // issued if the FIFO is guaranteed to have room for its data.
    assign pending = {1'b0, fifo_count}
                   + {{FIFO_CNT_W{1'b0}}, inflight_q}
                   - {{FIFO_CNT_W{1'b0}}, handshake};

    assign issue      = (state_q == ST_RUN) && (pending < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
    assign mem_re_o   = issue;
    assign mem_addr_o = addr_q;

    assign done   = (state_q == ST_DRAIN) && fifo_empty && !inflight_q;
    assign done_o = done;
    assign busy_o = (state_q != ST_IDLE) && !done;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remain_d        = remain_q;
        inflight_d      = issue;
        inflight_addr_d = issue ? addr_q : inflight_addr_q;
        accept          = 1'b0;

        case (state_q)
            ST_IDLE: accept = start_i;
            ST_RUN: begin
                if (issue) begin
                    addr_d   = addr_q + XLEN'(DW_STRIDE);
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    state_d = ST_IDLE;
                    // busy_o is already low here, so a start is honoured.
                    accept  = start_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A zero-length dump goes straight to DRAIN, which completes at once.
        if (accept) begin
            if (word_cnt_i != '0) begin
                addr_d   = base_addr_i & ~XLEN'(DW_STRIDE - 1);
                remain_d = word_cnt_i;
                state_d  = ST_RUN;
            end else begin
                state_d  = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    dump_skid_fifo #(
        .W (ENT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({inflight_addr_q, mem_rdata_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data and byte-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the doubleword count.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  single-cycle request to begin a dump.
REQ-006 SHALL have port base_addr_i  input  XLEN  byte address of the first doubleword.
REQ-007 SHALL have port word_cnt_i  input  CNT_W  number of doublewords to dump.
REQ-008 SHALL have port busy_o  output  1  high from start acceptance until done.
REQ-009 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_re_o  output  1  memory read strobe.
REQ-011 SHALL have port mem_addr_o  output  XLEN  memory byte address, valid when mem_re_o is high.
REQ-012 SHALL have port mem_rdata_i  input  XLEN  read data, valid exactly one cycle after mem_re_o.
REQ-013 SHALL have port dout_valid_o  output  1  stream word valid.
REQ-014 SHALL have port dout_ready_i  input  1  stream sink ready.
REQ-015 SHALL have port dout_data_o  output  XLEN  dumped doubleword.
REQ-016 SHALL have port dout_addr_o  output  XLEN  byte address tag of dout_data_o.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-018 IDLE: start_i with word_cnt_i != 0 SHALL latch the base and count, force base bits [2:0] to 0, and go to RUN; busy_o goes high on the next cycle.
REQ-019 IDLE: start_i with word_cnt_i == 0 SHALL issue no reads and pulse done_o in the next cycle.
REQ-020 start_i while busy_o is high SHALL be ignored.
REQ-021 RUN SHALL assert mem_re_o only when FIFO occupancy + in-flight reads - (pop this cycle) < 2.
REQ-022 Each issued read SHALL add 8 to the address, wrapping modulo 2^XLEN.
REQ-023 mem_rdata_i SHALL be pushed with its address tag into a 2-entry FIFO on the cycle after the read.
REQ-024 A handshake SHALL occur when dout_valid_o && dout_ready_i; it pops the FIFO head.
REQ-025 dout_data_o and dout_addr_o SHALL hold stable while dout_valid_o && !dout_ready_i.
REQ-026 Latency: with start at edge N, mem_re_o SHALL be high in cycle N+1 and dout_valid_o in cycle N+2.
REQ-027 With dout_ready_i held high, throughput SHALL be one word per cycle.
REQ-028 RUN SHALL go to DRAIN on the edge that issues the last read.
REQ-029 DRAIN SHALL go to IDLE when the FIFO is empty and no read is in flight, and SHALL pulse done_o for that one cycle; busy_o falls in the same cycle.
REQ-030 A simultaneous push and pop on a full FIFO SHALL be legal and SHALL keep the occupancy at 2.

Reset
REQ-031 While rst_n is low, the block SHALL be in IDLE with the FIFO empty, no read in flight, and busy_o, done_o, mem_re_o and dout_valid_o at 0.
REQ-032 While rst_n is low, mem_addr_o, dout_data_o and dout_addr_o SHALL be 0.
REQ-033 Reset asserted mid-dump SHALL abort the dump immediately, with no done_o pulse and any in-flight data discarded.

Structure
REQ-034 A shared package rv_dbg_pkg SHALL hold the FSM state enum, the doubleword byte stride (8) and the FIFO depth (2).
REQ-035 The FIFO SHALL be a sub-module named dump_skid_fifo.

Verification
REQ-036 Memory model MEM[addr>>3] = addr>>3; start base=0x40 cnt=4, ready=1 -> dout words 8,9,10,11 with tags 0x40..0x58, then done_o one cycle after the last handshake.
REQ-037 cnt=0 -> done_o the next cycle, mem_re_o never high.
REQ-038 Base=0x43 cnt=2 -> reads at 0x40 and 0x48.
REQ-039 Ready toggled 1-0-0-1 with cnt=6 -> six words in order, none lost or duplicated, and no more than 2 reads outstanding.
REQ-040 Base=0xFFFF_FFFF_FFFF_FFF8 cnt=2 -> second read at address 0.
REQ-041 rst_n pulsed low after 2 of 5 words -> all outputs 0, no done_o; a new start then dumps correctly.
